// File: rtl/move_arbiter_pkg.sv
// Shared playfield geometry, coordinate widths, FSM encodings and clamp helpers
// for the hero movement logic.
package move_arbiter_pkg;

  localparam int COORD_W   = 12;
  localparam int CALC_W    = COORD_W + 1;
  localparam int FIELD_W   = 1024;
  localparam int FIELD_H   = 768;
  localparam int DEF_OBJ_W = 32;
  localparam int DEF_OBJ_H = 32;
  localparam int DEF_BLK_W = 32;
  localparam int DEF_BLK_H = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Sum is widened by one bit so a step past the limit can never wrap.
  function automatic logic [COORD_W-1:0] clamp_add(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] step,
                                                   input logic [COORD_W-1:0] vmax);
    logic [CALC_W-1:0] s;
    s = {1'b0, v} + {1'b0, step};
    clamp_add = (s > {1'b0, vmax}) ? vmax : s[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] clamp_sub(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] step);
    clamp_sub = (v < step) ? '0 : v - step;
  endfunction

endpackage

// File: rtl/move_arbiter_aabb.sv
// Combinational axis-aligned rectangle overlap test; edges that only touch
// do not count as overlapping.
module aabb_overlap
  import move_arbiter_pkg::*;
#(
  parameter int A_W = DEF_OBJ_W,
  parameter int A_H = DEF_OBJ_H,
  parameter int B_W = DEF_BLK_W,
  parameter int B_H = DEF_BLK_H
) (
  input  logic [COORD_W-1:0] ax_i,
  input  logic [COORD_W-1:0] ay_i,
  input  logic [COORD_W-1:0] bx_i,
  input  logic [COORD_W-1:0] by_i,
  output logic               overlap_o
);

  logic [CALC_W-1:0] ax_e, ay_e, bx_e, by_e;
  logic [CALC_W-1:0] a_right, a_bot, b_right, b_bot;

  assign ax_e    = {1'b0, ax_i};
  assign ay_e    = {1'b0, ay_i};
  assign bx_e    = {1'b0, bx_i};
  assign by_e    = {1'b0, by_i};
  assign a_right = ax_e + CALC_W'(A_W);
  assign a_bot   = ay_e + CALC_W'(A_H);
  assign b_right = bx_e + CALC_W'(B_W);
  assign b_bot   = by_e + CALC_W'(B_H);

  assign overlap_o = (ax_e < b_right) && (bx_e < a_right) &&
                     (ay_e < b_bot)   && (by_e < a_bot);

endmodule

// File: rtl/move_arbiter.sv
// Per-tick hero movement: clamp a one-axis candidate, scan the wall table one
// entry per cycle, then commit the move or flag a collision.
module move_arbiter
  import move_arbiter_pkg::*;
#(
  parameter int X_INIT   = 512,
  parameter int Y_INIT   = 384,
  parameter int STEP     = 4,
  parameter int OBJ_W    = DEF_OBJ_W,
  parameter int OBJ_H    = DEF_OBJ_H,
  parameter int BLK_W    = DEF_BLK_W,
  parameter int BLK_H    = DEF_BLK_H,
  parameter int N_BLOCKS = 16,
  parameter int X_MAX    = FIELD_W - OBJ_W,
  parameter int Y_MAX    = FIELD_H - OBJ_H,
  parameter int IDX_W    = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               center,
  output logic [IDX_W-1:0]   blk_idx,
  input  logic [COORD_W-1:0] blk_x,
  input  logic [COORD_W-1:0] blk_y,
  input  logic               blk_en,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               collision,
  output logic               busy,
  output logic               move_done
);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_BLOCKS - 1);
  localparam logic [COORD_W-1:0] X_INIT_C = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] Y_INIT_C = COORD_W'(Y_INIT);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(Y_MAX);

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [IDX_W-1:0]   blk_idx_q, blk_idx_d;
  logic [IDX_W-1:0]   cmp_idx_q, cmp_idx_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic               collision_q, collision_d;
  logic               move_done_q, move_done_d;
  logic               overlap, hit;

  aabb_overlap #(
    .A_W(OBJ_W), .A_H(OBJ_H), .B_W(BLK_W), .B_H(BLK_H)
  ) u_overlap (
    .ax_i(cand_x_q), .ay_i(cand_y_q), .bx_i(blk_x), .by_i(blk_y),
    .overlap_o(overlap)
  );

  assign hit = blk_en && overlap;

  // cmp_valid_q/cmp_idx_q trail blk_idx by one cycle to match table latency.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    blk_idx_d   = blk_idx_q;
    cmp_idx_d   = blk_idx_q;
    cmp_valid_d = 1'b0;
    collision_d = collision_q;
    move_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (center) begin
            x_d         = X_INIT_C;
            y_d         = Y_INIT_C;
            collision_d = 1'b0;
            move_done_d = 1'b1;
          end else if (up || down || left || right) begin
            cand_x_d  = x_q;
            cand_y_d  = y_q;
            if (up)        cand_y_d = clamp_sub(y_q, STEP_C);
            else if (down) cand_y_d = clamp_add(y_q, STEP_C, Y_MAX_C);
            else if (left) cand_x_d = clamp_sub(x_q, STEP_C);
            else           cand_x_d = clamp_add(x_q, STEP_C, X_MAX_C);
            blk_idx_d = '0;
            state_d   = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (cmp_valid_q && hit) begin
          collision_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          if (blk_idx_q != LAST_IDX) blk_idx_d = blk_idx_q + 1'b1;
          if (cmp_valid_q && (cmp_idx_q == LAST_IDX)) state_d = ST_COMMIT;
          else                                        cmp_valid_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        x_d         = cand_x_q;
        y_d         = cand_y_q;
        collision_d = 1'b0;
        move_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= X_INIT_C;
      y_q         <= Y_INIT_C;
      cand_x_q    <= X_INIT_C;
      cand_y_q    <= Y_INIT_C;
      blk_idx_q   <= '0;
      cmp_idx_q   <= '0;
      cmp_valid_q <= 1'b0;
      collision_q <= 1'b0;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      blk_idx_q   <= blk_idx_d;
      cmp_idx_q   <= cmp_idx_d;
      cmp_valid_q <= cmp_valid_d;
      collision_q <= collision_d;
      move_done_q <= move_done_d;
    end
  end

  assign blk_idx   = blk_idx_q;
  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign collision = collision_q;
  assign busy      = (state_q != ST_IDLE);
  assign move_done = move_done_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Directed checks of move_arbiter: scan latency, clamping, wall hits, touching
// edges, ignored ticks, recentre and mid-scan reset.
module tb_move_arbiter;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
  logic [3:0]  blk_idx;
  logic [11:0] blk_x, blk_y;
  logic        blk_en;
  logic [11:0] x_pos, y_pos;
  logic        collision, busy, move_done;

  logic [11:0] mem_x  [N];
  logic [11:0] mem_y  [N];
  logic        mem_en [N];

  int err_cnt = 0;
  int chk_cnt = 0;
  int max_idx = 0;

  move_arbiter dut (
    .clk(clk), .rst(rst), .tick(tick),
    .up(up), .down(down), .left(left), .right(right), .center(center),
    .blk_idx(blk_idx), .blk_x(blk_x), .blk_y(blk_y), .blk_en(blk_en),
    .x_pos(x_pos), .y_pos(y_pos), .collision(collision),
    .busy(busy), .move_done(move_done)
  );

  always #5 clk = ~clk;

  // Wall table with one cycle of read latency.
  always @(posedge clk) begin
    blk_x  <= mem_x[blk_idx];
    blk_y  <= mem_y[blk_idx];
    blk_en <= mem_en[blk_idx];
  end

  task automatic check_val(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  // Issues one tick with the given buttons, then waits (bounded) for busy to drop.
  task automatic do_move(input logic u, input logic d, input logic l, input logic r,
                         input logic c, output int cyc, output logic done_seen);
    @(negedge clk);
    up = u; down = d; left = l; right = r; center = c; tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; center = 1'b0;
    max_idx   = int'(blk_idx);
    cyc       = -1;
    done_seen = 1'b0;
    if (!busy) begin
      cyc = 0;
      done_seen = move_done;
    end else begin
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (int'(blk_idx) > max_idx) max_idx = int'(blk_idx);
        if (!busy) begin
          cyc = n;
          done_seen = move_done;
          break;
        end
      end
    end
  endtask

  int   cyc;
  logic done;
  int   timeouts;
  int   pulses;

  initial begin
    for (int i = 0; i < N; i++) begin
      mem_x[i] = 12'd0; mem_y[i] = 12'd0; mem_en[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_x", int'(x_pos), 512);
    check_val("rst_y", int'(y_pos), 384);
    check_val("rst_flags", {collision, busy, move_done}, 0);
    check_val("rst_idx", int'(blk_idx), 0);
    rst = 1'b0;

    // 1: clear table, right move commits after 18 cycles
    do_move(0, 0, 0, 1, 0, cyc, done);
    check_val("t1_latency", cyc, 18);
    check_val("t1_done", int'(done), 1);
    check_val("t1_x", int'(x_pos), 516);
    check_val("t1_y", int'(y_pos), 384);
    check_val("t1_coll", int'(collision), 0);
    @(negedge clk);
    check_val("t1_done_1cyc", int'(move_done), 0);

    // 2: walk to the left edge, then a clamped left still scans and commits
    timeouts = 0;
    for (int i = 0; i < 129; i++) begin
      do_move(0, 0, 1, 0, 0, cyc, done);
      if (cyc != 18) timeouts++;
    end
    check_val("t2_walk_ok", timeouts, 0);
    check_val("t2_x_edge", int'(x_pos), 0);
    do_move(0, 0, 1, 0, 0, cyc, done);
    check_val("t2_clamp_latency", cyc, 18);
    check_val("t2_clamp_done", int'(done), 1);
    check_val("t2_clamp_x", int'(x_pos), 0);

    // Recentre
    do_move(0, 0, 0, 0, 1, cyc, done);
    check_val("recentre_x", int'(x_pos), 512);
    check_val("recentre_done", int'(done), 1);

    // 3: block 5 at (544,384) blocks a right move at entry 5
    mem_x[5] = 12'd544; mem_y[5] = 12'd384; mem_en[5] = 1'b1;
    do_move(0, 0, 0, 1, 0, cyc, done);
    check_val("t3_latency", cyc, 7);
    check_val("t3_coll", int'(collision), 1);
    check_val("t3_x", int'(x_pos), 512);
    check_val("t3_no_done", int'(done), 0);
    check_val("t3_max_idx", max_idx, 6);

    // Tick with no direction leaves collision alone
    do_move(0, 0, 0, 0, 0, cyc, done);
    check_val("nodir_coll", int'(collision), 1);
    check_val("nodir_x", int'(x_pos), 512);

    // 4: touching edge at x=548 does not overlap a hero moving to 516
    mem_en[5] = 1'b0;
    mem_x[3] = 12'd548; mem_y[3] = 12'd384; mem_en[3] = 1'b1;
    do_move(0, 0, 0, 1, 0, cyc, done);
    check_val("t4_latency", cyc, 18);
    check_val("t4_x", int'(x_pos), 516);
    check_val("t4_coll", int'(collision), 0);
    mem_en[3] = 1'b0;

    // 5: a second tick during SCAN is ignored
    @(negedge clk);
    right = 1'b1; tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    right = 1'b0; tick = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 3) begin tick = 1'b1; left = 1'b1; end
      else begin tick = 1'b0; left = 1'b0; end
      if (move_done) pulses++;
    end
    check_val("t5_pulses", pulses, 1);
    check_val("t5_x", int'(x_pos), 520);
    check_val("t5_busy", int'(busy), 0);

    // 6: move to (100,100), then centre+up recentres without scanning
    timeouts = 0;
    for (int i = 0; i < 105; i++) begin
      do_move(0, 0, 1, 0, 0, cyc, done);
      if (cyc != 18) timeouts++;
    end
    for (int i = 0; i < 71; i++) begin
      do_move(1, 0, 0, 0, 0, cyc, done);
      if (cyc != 18) timeouts++;
    end
    check_val("t6_walk_ok", timeouts, 0);
    check_val("t6_pre_x", int'(x_pos), 100);
    check_val("t6_pre_y", int'(y_pos), 100);
    do_move(1, 0, 0, 0, 1, cyc, done);
    check_val("t6_center_cyc", cyc, 0);
    check_val("t6_center_done", int'(done), 1);
    check_val("t6_center_x", int'(x_pos), 512);
    check_val("t6_center_y", int'(y_pos), 384);

    // Asynchronous reset in the middle of a scan
    @(negedge clk);
    down = 1'b1; tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    down = 1'b0; tick = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_mid_busy_before", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check_val("rst_mid_busy", int'(busy), 0);
    check_val("rst_mid_idx", int'(blk_idx), 0);
    check_val("rst_mid_y", int'(y_pos), 384);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (move_done) pulses++;
    end
    check_val("rst_mid_no_commit", pulses, 0);
    check_val("rst_mid_y_after", int'(y_pos), 384);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
